lsu_bus_master: RTL
===================

Name: lsu_bus_master

Overview:
- Bus initiator (load/store unit) for the data-side REQ/GNT bus; it is the requesting end opposite the boot ROM, RAM and peripheral responders.
- Accepts one load or store at a time from the execute stage and checks size and alignment.
- Drives o_REQ/o_HB/o_ADDR/o_WE/o_WDATA until GNT, then returns sign- or zero-extended load data with a one-cycle o_DONE pulse.
- A timeout counter turns a missing GNT into a bus fault, so an unmapped address cannot hang the core.

Parameters:
- TIMEOUT, 16, max cycles in WAIT without GNT before a bus fault (≥2).
- CNT_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RSTn  in  1  synchronous active-low reset.
- i_VALID  in  1  core request valid.
- i_WE  in  1  1 = store, 0 = load.
- i_FUNCT3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_ADDR  in  32  byte address.
- i_WDATA  in  32  store data, right-justified.
- o_READY  out  1  unit idle, request accepted this cycle if i_VALID.
- o_DONE  out  1  one-cycle completion pulse.
- o_RDATA  out  32  extended load data, valid with o_DONE.
- o_FAULT  out  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal size; valid with o_DONE.
- o_REQ  out  1  bus request.
- o_WE  out  1  bus write enable.
- o_HB  out  2  bus size: 00 byte, 01 half, 10 word.
- o_ADDR  out  32  bus byte address.
- o_WDATA  out  32  bus write data, right-justified, masked to size.
- i_GNT  in  1  responder grant; read data valid in same cycle.
- i_RDATA  in  32  responder read data, right-justified (lane select done by responder).

Behaviour:
- Reset (i_RSTn=0 at edge): state IDLE, o_DONE=0, o_RDATA=0, o_FAULT=00, counter 0, latched request cleared. o_REQ is gated by i_RSTn, so it is 0 in any cycle reset is asserted, including mid-transaction. A transaction aborted by reset produces no o_DONE.
- States: IDLE, WAIT, RESP.
- IDLE: o_READY=1. On i_VALID, latch i_WE, i_FUNCT3, i_ADDR and i_WDATA masked to size.
  - Illegal funct3 (011, 110, 111; or BU/HU with i_WE=1) → RESP with fault 11, no bus access.
  - Misaligned → RESP with fault 01, no bus access. Halfword is misaligned when addr[0]=1. Word is misaligned when addr[1:0]≠00.
  - Otherwise → WAIT, counter cleared.
- WAIT:
  - o_REQ = ~i_GNT (combinational drop). Consequence: a responder that registers REQ sees it low on the grant edge and does not grant again.
  - o_ADDR/o_HB/o_WE/o_WDATA hold the latched values for the whole WAIT state.
  - On i_GNT: capture the extended i_RDATA for loads (o_RDATA=0 for stores), set fault 00 → RESP.
  - Otherwise increment the counter. When counter == TIMEOUT-1 and no GNT: fault 10, o_RDATA=0 → RESP. GNT in that same cycle wins and yields fault 00.
- RESP: o_DONE=1 for exactly one cycle, then IDLE. o_READY=0 in WAIT and RESP.
- Outside WAIT: o_REQ=0, o_WE=0, o_HB/o_ADDR/o_WDATA hold their last values.
- o_RDATA and o_FAULT are registered and held until the next o_DONE.
- Load extension uses only i_RDATA[7:0] or [15:0]; upper bits are ignored.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass all 32 bits.
- HB encoding: B/BU→00, H/HU→01, W→10.
- Latency, zero-wait-state responder with registered GNT:
  - Accept edge E0; o_REQ high in cycle 1.
  - GNT in cycle 2.
  - o_DONE in cycle 3.
  - Next accept possible cycle 4.
- Fault latency: o_DONE one cycle after accept, o_REQ never asserted.
- A GNT seen outside WAIT is ignored.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B/H/W/BU/HU.
  - HB_BYTE/HALF/WORD.
  - FAULT_OK/MISALIGN/TIMEOUT/ILLEGAL.
  - State encoding IDLE/WAIT/RESP.
  - Functions for size→HB mapping and write-data masking.
- Sub-module lsu_load_ext: combinational extender (funct3, raw data → 32-bit result), reusable by the fetch path.

Test Plan:
- LB from 0x13 on a ROM model where word 0x10 = 0x8081F2F3 and bytes are returned right-justified (i_RDATA=0x80) → o_HB=00, o_ADDR=0x13, o_REQ high exactly one cycle, o_DONE in cycle 3, o_RDATA=0xFFFFFF80, o_FAULT=00.
- LHU then LH from 0x12 (i_RDATA=0x8081) → 0x00008081 then 0xFFFF8081; back-to-back accepts 4 cycles apart.
- SH 0x12 with i_WDATA=0xDEADBEEF → o_WE=1, o_HB=01, o_WDATA=0x0000BEEF. Also LW from 0x2 → no o_REQ, o_DONE next cycle, o_FAULT=01.
- Responder with GNT delayed 5 cycles → o_REQ and o_ADDR stable 6 cycles, o_REQ=0 in the GNT cycle, single o_DONE.
- No GNT with TIMEOUT=16 → o_DONE 17 cycles after accept, o_FAULT=10, o_REQ low from then on. funct3=011 → o_FAULT=11.
- Reset asserted during WAIT → o_REQ=0 that cycle, no o_DONE, o_READY=1 after release; a later GNT pulse is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and size helpers for the data-side load/store unit.
// The fetch path reuses the funct3 and HB encodings.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Illegal codes fall through to byte; they never reach the bus.
    function automatic logic [1:0] size_to_hb(input logic [2:0] funct3);
        case (funct3)
            F3_H, F3_HU: return HB_HALF;
            F3_W:        return HB_WORD;
            default:     return HB_BYTE;
        endcase
    endfunction

    function automatic logic [31:0] mask_wdata(input logic [2:0] funct3, input logic [31:0] data);
        case (size_to_hb(funct3))
            HB_BYTE: return {24'h0, data[7:0]};
            HB_HALF: return {16'h0, data[15:0]};
            default: return data;
        endcase
    endfunction

    // Unsigned load codes have no store counterpart.
    function automatic logic is_illegal(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] hb, input logic [1:0] addr_lo);
        case (hb)
            HB_HALF: return addr_lo[0];
            HB_WORD: return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extender: picks the low byte/half and sign- or zero-extends
// it according to the RV32I funct3 size code.
module lsu_load_ext
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);
    import lsu_pkg::*;

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
            F3_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
            F3_BU:   o_data = {24'h0, i_data[7:0]};
            F3_HU:   o_data = {16'h0, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: one request at a time, size/alignment screening,
// REQ held until GNT, and a timeout so an unmapped address cannot stall the core.
module lsu_bus_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_VALID,
    input  logic        i_WE,
    input  logic [2:0]  i_FUNCT3,
    input  logic [31:0] i_ADDR,
    input  logic [31:0] i_WDATA,
    output logic        o_READY,
    output logic        o_DONE,
    output logic [31:0] o_RDATA,
    output logic [1:0]  o_FAULT,
    output logic        o_REQ,
    output logic        o_WE,
    output logic [1:0]  o_HB,
    output logic [31:0] o_ADDR,
    output logic [31:0] o_WDATA,
    input  logic        i_GNT,
    input  logic [31:0] i_RDATA
);
    import lsu_pkg::*;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         hb_q, hb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         fault_q, fault_d;
    logic [31:0]        ext_data;

    lsu_load_ext u_load_ext (
        .i_funct3 (funct3_q),
        .i_data   (i_RDATA),
        .o_data   (ext_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hb_d     = hb_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;

        case (state_q)
            IDLE: begin
                if (i_VALID) begin
                    we_d     = i_WE;
                    funct3_d = i_FUNCT3;
                    addr_d   = i_ADDR;
                    wdata_d  = mask_wdata(i_FUNCT3, i_WDATA);
                    hb_d     = size_to_hb(i_FUNCT3);
                    cnt_d    = '0;
                    // Screening faults skip the bus and complete on the next cycle.
                    if (is_illegal(i_FUNCT3, i_WE)) begin
                        fault_d = FAULT_ILLEGAL;
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (is_misaligned(size_to_hb(i_FUNCT3), i_ADDR[1:0])) begin
                        fault_d = FAULT_MISALIGN;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // A grant in the final counted cycle still wins over the timeout.
                if (i_GNT) begin
                    rdata_d = we_q ? 32'h0 : ext_data;
                    fault_d = FAULT_OK;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    fault_d = FAULT_TIMEOUT;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            hb_q     <= HB_BYTE;
            rdata_q  <= '0;
            fault_q  <= FAULT_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hb_q     <= hb_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // REQ drops combinationally on GNT so a registered responder does not grant twice.
    assign o_REQ   = i_RSTn & (state_q == WAIT) & ~i_GNT;
    assign o_WE    = (state_q == WAIT) & we_q;
    assign o_HB    = hb_q;
    assign o_ADDR  = addr_q;
    assign o_WDATA = wdata_q;
    assign o_READY = (state_q == IDLE);
    assign o_DONE  = (state_q == RESP);
    assign o_RDATA = rdata_q;
    assign o_FAULT = fault_q;

endmodule
